// File: rtl/alu_muldiv_ctrl.sv
// RV32M multiply/divide sequencer: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with pipeline stall generation and flush/abort handling.
module alu_muldiv_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_flush,
    output logic        o_ready,
    output logic        o_valid,
    output logic [31:0] o_result,
    output logic        o_stall
);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;

    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] opnd_q;
    logic [63:0] acc_q;
    logic [32:0] rem_q;

    logic        accept;
    logic        is_div, a_signed, b_signed, a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    logic        div_by_zero, div_ovf, special;
    logic [31:0] special_res;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [33:0] rem_shift, rem_diff;
    logic        div_ge;
    logic [32:0] rem_next;
    logic [31:0] quo_next;
    logic [63:0] prod;
    logic [31:0] quot, remd, fix_res;

    assign accept = (state_q == S_IDLE) && i_valid && !i_flush;

    always_comb begin
        is_div      = op_q[2];
        a_signed    = (op_q != OP_MULHU) && (op_q != OP_DIVU) && (op_q != OP_REMU);
        b_signed    = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
        a_neg       = a_signed && a_q[31];
        b_neg       = b_signed && b_q[31];
        mag_a       = a_neg ? -a_q : a_q;
        mag_b       = b_neg ? -b_q : b_q;
        div_by_zero = is_div && (b_q == 32'd0);
        div_ovf     = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                      (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
        special     = div_by_zero || div_ovf;
        // op_q[1] separates the remainder ops from the quotient ops
        if (div_by_zero)
            special_res = op_q[1] ? a_q : 32'hFFFF_FFFF;
        else
            special_res = op_q[1] ? 32'd0 : 32'h8000_0000;
    end

    // Per-iteration datapath: acc low half holds multiplier (mul) or dividend/quotient (div)
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};
        rem_shift = {rem_q, acc_q[31]};
        rem_diff  = rem_shift - {2'b00, opnd_q};
        div_ge    = !rem_diff[33];
        rem_next  = div_ge ? rem_diff[32:0] : rem_shift[32:0];
        quo_next  = {acc_q[30:0], div_ge};
    end

    always_comb begin
        prod = (a_neg ^ b_neg) ? -acc_q : acc_q;
        quot = (a_neg ^ b_neg) ? -acc_q[31:0] : acc_q[31:0];
        remd = a_neg ? -rem_q[31:0] : rem_q[31:0];
        case (op_q)
            OP_MUL:                      fix_res = prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[63:32];
            OP_DIV, OP_DIVU:             fix_res = quot;
            default:                     fix_res = remd;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_PREP;
            end
            S_PREP: begin
                cnt_d = 6'd0;
                if (i_flush) begin
                    state_d = S_IDLE;
                end else if (special) begin
                    state_d  = S_DONE;
                    result_d = special_res;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (i_flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 6'd31) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_FIX: begin
                if (i_flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_DONE;
                    result_d = fix_res;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready  = (state_q == S_IDLE);
        o_valid  = (state_q == S_DONE);
        o_stall  = (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX) || accept;
        o_result = result_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Operand and iteration registers carry no reset; they are always loaded before use
    always_ff @(posedge i_clk) begin
        if (accept) begin
            op_q <= i_op;
            a_q  <= i_a;
            b_q  <= i_b;
        end
        if (state_q == S_PREP) begin
            opnd_q <= is_div ? mag_b : mag_a;
            acc_q  <= {32'd0, (is_div ? mag_a : mag_b)};
            rem_q  <= 33'd0;
        end else if (state_q == S_CALC) begin
            if (is_div) begin
                acc_q <= {acc_q[63:32], quo_next};
                rem_q <= rem_next;
            end else begin
                acc_q <= mul_next;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Directed and randomized bench for alu_muldiv_ctrl against a plain-arithmetic RV32M model.
module tb_alu_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst, valid, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        ready, ovalid, stall;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res;

    alu_muldiv_ctrl dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (valid),
        .i_op     (op),
        .i_a      (a),
        .i_b      (b),
        .i_flush  (flush),
        .o_ready  (ready),
        .o_valid  (ovalid),
        .o_result (result),
        .o_stall  (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, p;
        longint unsigned ux, uy, up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * longint'(uy); return p[63:32]; end
            3'd3: begin up = ux * uy; return up[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                p = sx / sy;
                return p[31:0];
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                up = ux / uy;
                return up[31:0];
            end
            3'd6: begin
                if (y == 0) return x;
                p = sx % sy;
                return p[31:0];
            end
            default: begin
                if (y == 0) return x;
                up = ux % uy;
                return up[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && y == 0) return 1'b1;
        if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1'b1;
        return 1'b0;
    endfunction

    // Starts right after a falling edge with the DUT idle; ends after a falling edge, idle again.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp);
        int          lat, got, stall_bad, held_bad;
        logic [31:0] res;
        lat       = is_special(o, x, y) ? 2 : 35;
        got       = 0;
        stall_bad = 0;
        held_bad  = 0;
        res       = '0;
        valid = 1'b1; op = o; a = x; b = y; flush = 1'b0;
        #1;
        chk({tag, "_ready_at_issue"}, ready, 1);
        chk({tag, "_stall_at_issue"}, stall, 1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        op    = 3'($urandom);
        a     = $urandom;
        b     = $urandom;
        for (int k = 1; k <= 60 && got == 0; k++) begin
            @(negedge clk);
            if (ovalid) begin
                got = k;
                res = result;
                if (stall) stall_bad++;
            end else begin
                if (!stall) stall_bad++;
                if (result !== last_res) held_bad++;
            end
        end
        chk({tag, "_latency"}, got, lat);
        chk({tag, "_result"}, res, exp);
        chk({tag, "_stall_profile"}, stall_bad, 0);
        chk({tag, "_result_held"}, held_bad, 0);
        @(negedge clk);
        chk({tag, "_ready_after"}, ready, 1);
        chk({tag, "_valid_one_cycle"}, ovalid, 0);
        chk({tag, "_result_kept"}, result, exp);
        last_res = exp;
    endtask

    initial begin
        int          bad;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        rst = 1'b1; valid = 1'b0; flush = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        last_res = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_ready", ready, 1);
        chk("reset_valid", ovalid, 0);
        chk("reset_stall", stall, 0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);

        run_op("mulh_min",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mul_min",    3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
        run_op("mulhsu_m1",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhu_max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("div_neg7",   3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        run_op("rem_neg7",   3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        run_op("divu_big",   3'd5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC);
        run_op("divu_zero",  3'd5, 32'd7,         32'd0,         32'hFFFF_FFFF);
        run_op("remu_zero",  3'd7, 32'd7,         32'd0,         32'h0000_0007);
        run_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

        // flush in the middle of a multiply, then a divide right behind it
        bad = 0;
        valid = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
        @(posedge clk);
        #1 valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (ovalid || !stall) bad++;
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        if (ovalid) bad++;
        chk("flush_idle_ready", ready, 1);
        chk("flush_no_valid", bad, 0);
        chk("flush_result_kept", result, last_res);
        run_op("divu_after_flush", 3'd5, 32'd100, 32'd7, 32'd14);

        // flush and request together in idle: no accept
        valid = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
        #1 chk("idle_flush_stall", stall, 0);
        @(posedge clk);
        #1 begin valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        chk("idle_flush_not_accepted", ready, 1);

        // asynchronous reset in the middle of a divide
        bad = 0;
        valid = 1'b1; op = 3'd4; a = $urandom; b = 32'd3;
        @(posedge clk);
        #1 valid = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (ovalid) bad++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ready", ready, 1);
        chk("midrst_result", result, 32'd0);
        chk("midrst_valid", ovalid, 0);
        @(negedge clk);
        rst = 1'b0;
        last_res = 32'd0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ovalid) bad++;
        end
        chk("midrst_never_valid", bad, 0);

        for (int n = 0; n < 24; n++) begin
            ro = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: ra = 32'($urandom_range(0, 50));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d_op%0d", n, ro), ro, ra, rb, ref_model(ro, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_ctrl.md
# alu_muldiv_ctrl

Multi-cycle sequencer for the RV32M multiply/divide operations of the CPU's ALU. Accepts one operation at a time from the execute stage, runs a radix-2 iterative shift-add multiply or restoring divide under an FSM, and returns a 32-bit result with a one-cycle valid pulse. It produces the stall the ALU forwards to the pipeline while an operation is in flight.

## Interface

Parameters: none. The width is fixed at 32.

- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  reset; asynchronous, active-high
- i_valid  in  1  operation request
- i_op  in  3  RV32M funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_a  in  32  rs1 operand (multiplicand / dividend)
- i_b  in  32  rs2 operand (multiplier / divisor)
- i_flush  in  1  abort the in-flight operation
- o_ready  out  1  high only in IDLE
- o_valid  out  1  one-cycle result pulse
- o_result  out  32  result; holds its value until the next o_valid
- o_stall  out  1  pipeline hold

## Operation

- States: IDLE, PREP, CALC, FIX, DONE.
- **Accept:** i_valid & o_ready & !i_flush. Latch i_op, i_a and i_b.
- **IDLE → PREP** on accept.
- **PREP:**
  - Take operand magnitudes per signedness: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats a as signed and b as unsigned; MULHU/DIVU/REMU treat both as unsigned.
  - Record the result sign.
  - Clear the 6-bit iteration counter.
- **PREP → DONE** directly for these special cases:
  - Divide by zero (b == 0): DIV/DIVU → 0xFFFFFFFF; REM/REMU → a.
  - Signed overflow (DIV/REM, a = 0x80000000, b = 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- **PREP → CALC** otherwise.
- **CALC:** exactly 32 cycles, one bit per cycle.
  - Multiply: 64-bit accumulator, shift-add on magnitudes.
  - Divide: restoring division on magnitudes using a 33-bit partial remainder.
  - Counter 0..31; **CALC → FIX** when the counter reaches 31.
- **FIX:**
  - Apply the sign.
  - Negate the 64-bit product if the sign is negative.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder takes the sign of the dividend.
  - Select the result: MUL → product[31:0]; MULH/MULHSU/MULHU → product[63:32]; DIV/DIVU → quotient; REM/REMU → remainder.
  - Register the result into o_result.
  - **FIX → DONE.**
- **DONE:** o_valid = 1 for one cycle; **DONE → IDLE.**
- **o_stall** = (state ∈ {PREP, CALC, FIX}) | (state == IDLE & i_valid & !i_flush). This is combinational, so the requesting instruction stalls in its issue cycle. o_stall is low in DONE, so the pipeline advances the same cycle o_valid is high.
- **i_flush:**
  - In any non-IDLE state: next state is IDLE, no o_valid, o_result unchanged.
  - In DONE, flush suppresses nothing: o_valid is already high that cycle and the next state is IDLE regardless.
- **Flush with i_valid in IDLE:** the flush wins and the request is not accepted.
- **Ignored inputs:** i_valid/i_op/i_a/i_b outside IDLE are ignored. Latched operands are immune to input changes after accept.

## Timing

- **Reset values:** state = IDLE, o_ready = 1, o_valid = 0, o_stall = 0 (with i_valid low), o_result = 0, counter = 0.
- **Reset mid-operation:** immediate return to IDLE, no o_valid.
- **Normal op accepted in cycle t:**
  - PREP at t+1.
  - CALC t+2..t+33.
  - FIX t+34.
  - DONE/o_valid at t+35.
  - o_ready again at t+36.
  - Earliest next accept is t+36 (throughput of one op per 36 cycles).
- **Special case accepted in cycle t:** PREP t+1, DONE/o_valid t+2, o_ready t+3.
- o_result changes only on the edge that enters DONE and is stable while o_valid is high.

## Test plan

- **MULH**, a = 0x80000000, b = 0x80000000 → o_result 0x40000000, o_valid exactly at t+35. Same operands with **MUL** → 0x00000000.
- **MULHSU**, a = 0xFFFFFFFF, b = 0xFFFFFFFF → 0xFFFFFFFF. **MULHU** same operands → 0xFFFFFFFE.
- **DIV** a = 0xFFFFFFF9 (−7), b = 2 → 0xFFFFFFFD. **REM** same operands → 0xFFFFFFFF. **DIVU** same operands → 0x7FFFFFFC.
- **DIVU** 7/0 → 0xFFFFFFFF; **REMU** 7/0 → 0x00000007. **DIV** 0x80000000 / 0xFFFFFFFF → 0x80000000; **REM** same operands → 0. All four give o_valid at t+2.
- **i_flush mid-op:** MUL with 3 × 5; assert i_flush at t+10.
  - Required: IDLE at t+11, no o_valid, o_result keeps its previous value.
  - Then DIVU 100 / 7 accepted at t+11 → 14 at t+46.
- **Reset mid-op:** assert i_rst at t+20 of a DIV.
  - Required: o_ready = 1, o_result = 0, o_valid never pulses.
- **Stall check across all scenarios:** o_stall high from the accept cycle through FIX, low in DONE.
